// File: rtl/double_to_pcm16_iter_pkg.sv
// Shared definitions for the double-to-PCM16 iterative converter:
// binary64 field constants, PCM limits, the FSM state type and a
// helper that splits a binary64 word into sign, exponent and fraction.
package double_to_pcm16_iter_pkg;

  localparam int DBL_BIAS   = 1023;
  localparam int DBL_EXP_W  = 11;
  localparam int DBL_FRAC_W = 52;

  localparam logic [15:0] PCM_MAX = 16'h7FFF;
  localparam logic [15:0] PCM_MIN = 16'h8000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_UNPACK,
    ST_SHIFT,
    ST_ROUND,
    ST_DONE
  } state_t;

  typedef struct packed {
    logic                  sign;
    logic [DBL_EXP_W-1:0]  expo;
    logic [DBL_FRAC_W-1:0] frac;
  } dbl_fields_t;

  function automatic dbl_fields_t split_double(input logic [63:0] d);
    dbl_fields_t f;
    f.sign = d[63];
    f.expo = d[62:52];
    f.frac = d[51:0];
    return f;
  endfunction

endpackage

// File: rtl/pcm16_round_sat.sv
// Round-to-nearest-even, positive saturation and sign application for
// a 15-bit integer magnitude plus its guard and sticky bits.
// With DOUBLE_TO_PCM_FLAGS_EN defined it also reports saturated/inexact.
module pcm16_round_sat
  import double_to_pcm16_iter_pkg::*;
(
  input  logic [14:0] mag,
  input  logic        guard,
  input  logic        sticky,
  input  logic        sign,
`ifdef DOUBLE_TO_PCM_FLAGS_EN
  output logic        saturated,
  output logic        inexact,
`endif
  output logic [15:0] result
);

  logic        inc;
  logic [15:0] rounded;

  // Round the magnitude, clamp +32768 to the positive limit, then negate for negative samples
  always_comb begin
    inc     = guard & (sticky | mag[0]);
    rounded = {1'b0, mag} + {15'd0, inc};
    result  = rounded;
    if (sign) begin
      result = ~rounded + 16'd1;
    end else if (rounded[15]) begin
      result = PCM_MAX;
    end
  end

`ifdef DOUBLE_TO_PCM_FLAGS_EN
  // Only a positive rounded magnitude of 32768 is out of range; -32768 is exact
  always_comb begin
    saturated = ~sign & rounded[15];
    inexact   = guard | sticky | saturated;
  end
`endif

endmodule

// File: rtl/double_to_pcm16_iter.sv
// Multi-cycle IEEE-754 binary64 to signed 16-bit PCM converter.
// The mantissa is shifted right STEP_BITS bits per cycle to keep the
// shifter small. Optional flag outputs: define DOUBLE_TO_PCM_FLAGS_EN.
module double_to_pcm16_iter
  import double_to_pcm16_iter_pkg::*;
#(
  parameter int STEP_BITS = 4
) (
  input  logic        clk_operation,
  input  logic        rst,
  input  logic        enable,
  input  logic [63:0] double,
`ifdef DOUBLE_TO_PCM_FLAGS_EN
  output logic        saturated,
  output logic        inexact,
`endif
  output logic [15:0] sig16b,
  output logic        ready,
  output logic        busy
);

  localparam logic [5:0]           STEP_W   = 6'(STEP_BITS);
  localparam logic [DBL_EXP_W-1:0] EXP_SAT  = DBL_EXP_W'(DBL_BIAS + 15);
  localparam logic [DBL_EXP_W-1:0] EXP_HALF = DBL_EXP_W'(DBL_BIAS - 1);
  localparam logic [DBL_EXP_W-1:0] SH_BASE  = DBL_EXP_W'(DBL_BIAS + DBL_FRAC_W);

  state_t      state_q, state_d;
  logic [63:0] dbl_q, dbl_d;
  logic [52:0] mant_q, mant_d;
  logic [1:0]  gr_q, gr_d;
  logic        sticky_q, sticky_d;
  logic [5:0]  rem_q, rem_d;
  logic        special_q, special_d;
  logic [15:0] spec_val_q, spec_val_d;
  logic [15:0] res_q, res_d;
  logic [15:0] sig16b_q, sig16b_d;
  logic        ready_q, ready_d;
  logic        busy_q, busy_d;

  dbl_fields_t fields;
  logic [5:0]  step;
  logic [54:0] ext;
  logic [54:0] ext_sh;
  logic        lost;
  logic [15:0] rs_result;

`ifdef DOUBLE_TO_PCM_FLAGS_EN
  logic spec_sat_q, spec_sat_d;
  logic spec_inx_q, spec_inx_d;
  logic res_sat_q, res_sat_d;
  logic res_inx_q, res_inx_d;
  logic sat_q, sat_d;
  logic inx_q, inx_d;
  logic rs_sat, rs_inx;
`endif

  pcm16_round_sat u_round (
    .mag      (mant_q[14:0]),
    .guard    (gr_q[1]),
    .sticky   (gr_q[0] | sticky_q),
    .sign     (fields.sign),
`ifdef DOUBLE_TO_PCM_FLAGS_EN
    .saturated(rs_sat),
    .inexact  (rs_inx),
`endif
    .result   (rs_result)
  );

  // Next-state and datapath logic for the IDLE/UNPACK/SHIFT/ROUND/DONE sequence
  always_comb begin
    state_d    = state_q;
    dbl_d      = dbl_q;
    mant_d     = mant_q;
    gr_d       = gr_q;
    sticky_d   = sticky_q;
    rem_d      = rem_q;
    special_d  = special_q;
    spec_val_d = spec_val_q;
    res_d      = res_q;
    sig16b_d   = sig16b_q;
    ready_d    = 1'b0;
    busy_d     = busy_q;
`ifdef DOUBLE_TO_PCM_FLAGS_EN
    spec_sat_d = spec_sat_q;
    spec_inx_d = spec_inx_q;
    res_sat_d  = res_sat_q;
    res_inx_d  = res_inx_q;
    sat_d      = sat_q;
    inx_d      = inx_q;
`endif

    fields = split_double(dbl_q);
    step   = (rem_q < STEP_W) ? rem_q : STEP_W;
    ext    = {mant_q, gr_q};
    lost   = 1'b0;
    for (int i = 0; i < STEP_BITS; i++) begin
      if (i < int'(step)) lost = lost | ext[i];
    end
    ext_sh = ext >> step;

    case (state_q)
      ST_IDLE: begin
        if (enable && !ready_q) begin
          dbl_d   = double;
          busy_d  = 1'b1;
          state_d = ST_UNPACK;
        end
      end

      ST_UNPACK: begin
        mant_d     = {1'b1, fields.frac};
        gr_d       = 2'b00;
        sticky_d   = 1'b0;
        rem_d      = 6'(SH_BASE - fields.expo);
        special_d  = 1'b1;
        spec_val_d = 16'h0000;
        state_d    = ST_ROUND;
`ifdef DOUBLE_TO_PCM_FLAGS_EN
        spec_sat_d = 1'b0;
        spec_inx_d = 1'b0;
`endif
        if (fields.expo == '1) begin
          if (fields.frac == '0) begin
            spec_val_d = fields.sign ? PCM_MIN : PCM_MAX;
`ifdef DOUBLE_TO_PCM_FLAGS_EN
            spec_sat_d = 1'b1;
            spec_inx_d = 1'b1;
`endif
          end else begin
`ifdef DOUBLE_TO_PCM_FLAGS_EN
            spec_inx_d = 1'b1;
`endif
          end
        end else if (fields.expo == '0) begin
          spec_val_d = 16'h0000;
        end else if (fields.expo >= EXP_SAT) begin
          spec_val_d = fields.sign ? PCM_MIN : PCM_MAX;
`ifdef DOUBLE_TO_PCM_FLAGS_EN
          spec_sat_d = !(fields.sign && fields.expo == EXP_SAT && fields.frac == '0);
          spec_inx_d = !(fields.sign && fields.expo == EXP_SAT && fields.frac == '0);
`endif
        end else if (fields.expo < EXP_HALF) begin
          spec_val_d = 16'h0000;
        end else begin
          special_d = 1'b0;
          state_d   = ST_SHIFT;
        end
      end

      ST_SHIFT: begin
        mant_d   = ext_sh[54:2];
        gr_d     = ext_sh[1:0];
        sticky_d = sticky_q | lost;
        rem_d    = rem_q - step;
        if (rem_q == step) state_d = ST_ROUND;
      end

      ST_ROUND: begin
        res_d   = special_q ? spec_val_q : rs_result;
`ifdef DOUBLE_TO_PCM_FLAGS_EN
        res_sat_d = special_q ? spec_sat_q : rs_sat;
        res_inx_d = special_q ? spec_inx_q : rs_inx;
`endif
        state_d = ST_DONE;
      end

      ST_DONE: begin
        sig16b_d = res_q;
        ready_d  = 1'b1;
        busy_d   = 1'b0;
`ifdef DOUBLE_TO_PCM_FLAGS_EN
        sat_d    = res_sat_q;
        inx_d    = res_inx_q;
`endif
        state_d  = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset discards any conversion in flight
  always_ff @(posedge clk_operation) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      dbl_q      <= '0;
      mant_q     <= '0;
      gr_q       <= '0;
      sticky_q   <= 1'b0;
      rem_q      <= '0;
      special_q  <= 1'b0;
      spec_val_q <= '0;
      res_q      <= '0;
      sig16b_q   <= '0;
      ready_q    <= 1'b0;
      busy_q     <= 1'b0;
`ifdef DOUBLE_TO_PCM_FLAGS_EN
      spec_sat_q <= 1'b0;
      spec_inx_q <= 1'b0;
      res_sat_q  <= 1'b0;
      res_inx_q  <= 1'b0;
      sat_q      <= 1'b0;
      inx_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      dbl_q      <= dbl_d;
      mant_q     <= mant_d;
      gr_q       <= gr_d;
      sticky_q   <= sticky_d;
      rem_q      <= rem_d;
      special_q  <= special_d;
      spec_val_q <= spec_val_d;
      res_q      <= res_d;
      sig16b_q   <= sig16b_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
`ifdef DOUBLE_TO_PCM_FLAGS_EN
      spec_sat_q <= spec_sat_d;
      spec_inx_q <= spec_inx_d;
      res_sat_q  <= res_sat_d;
      res_inx_q  <= res_inx_d;
      sat_q      <= sat_d;
      inx_q      <= inx_d;
`endif
    end
  end

  assign sig16b = sig16b_q;
  assign ready  = ready_q;
  assign busy   = busy_q;
`ifdef DOUBLE_TO_PCM_FLAGS_EN
  assign saturated = sat_q;
  assign inexact   = inx_q;
`endif

endmodule

// File: tb/tb_double_to_pcm16_iter.sv
// Directed bench for double_to_pcm16_iter: three instances (STEP_BITS 1, 4, 8)
// share stimulus; each scenario task checks results, latency and handshake.
module tb_double_to_pcm16_iter;

  logic        clk_operation = 1'b0;
  logic        rst;
  logic        enable;
  logic [63:0] dbl;
  logic [15:0] sig [3];
  logic        rdy [3];
  logic        bsy [3];

  int steps [3] = '{1, 4, 8};
  int tests_run = 0;
  int tests_failed = 0;
  int lat [3];
  int pulses [3];
  logic bsy1 [3];

  // Free-running operation clock
  always #5 clk_operation = ~clk_operation;

  double_to_pcm16_iter #(.STEP_BITS(1)) u_step1 (
    .clk_operation(clk_operation), .rst(rst), .enable(enable), .double(dbl),
    .sig16b(sig[0]), .ready(rdy[0]), .busy(bsy[0]));
  double_to_pcm16_iter #(.STEP_BITS(4)) u_step4 (
    .clk_operation(clk_operation), .rst(rst), .enable(enable), .double(dbl),
    .sig16b(sig[1]), .ready(rdy[1]), .busy(bsy[1]));
  double_to_pcm16_iter #(.STEP_BITS(8)) u_step8 (
    .clk_operation(clk_operation), .rst(rst), .enable(enable), .double(dbl),
    .sig16b(sig[2]), .ready(rdy[2]), .busy(bsy[2]));

  // Starts one conversion, optionally re-pulses enable at cycle reen, and records
  // ready latency, pulse count and busy one cycle after acceptance (70-cycle bound)
  task automatic convert(input logic [63:0] val, input int reen, input logic [63:0] val2);
    dbl = val;
    enable = 1'b1;
    @(posedge clk_operation); #1;
    enable = 1'b0;
    dbl = ~val;
    for (int i = 0; i < 3; i++) begin
      lat[i] = 0;
      pulses[i] = 0;
    end
    for (int c = 1; c <= 70; c++) begin
      if (reen != 0 && c == reen) begin
        enable = 1'b1;
        dbl = val2;
      end
      @(posedge clk_operation); #1;
      enable = 1'b0;
      for (int i = 0; i < 3; i++) begin
        if (c == 1) bsy1[i] = bsy[i];
        if (rdy[i] === 1'b1) begin
          pulses[i]++;
          if (lat[i] == 0) lat[i] = c;
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    enable = 1'b0;
    dbl = 64'd0;
    repeat (2) @(posedge clk_operation);
    #1;
    for (int i = 0; i < 3; i++) begin
      tests_run++;
      if (sig[i] !== 16'h0000 || rdy[i] !== 1'b0 || bsy[i] !== 1'b0) begin
        tests_failed++;
        $display("[TB] FAIL reset step%0d: got sig=%h ready=%b busy=%b, want 0000/0/0",
                 steps[i], sig[i], rdy[i], bsy[i]);
      end
    end
    rst = 1'b0;
    @(posedge clk_operation); #1;
  endtask

  task automatic test_normal();
    logic [63:0] vals [12] = '{
      64'h3FF0000000000000, 64'h4004000000000000, 64'hC00C000000000000,
      64'h3FF8000000000000, 64'hBFF0000000000000, 64'h3FF4000000000000,
      64'h4059000000000000, 64'h3FE0000000000000, 64'h3FE8000000000000,
      64'h4006000000000000, 64'h40DFFFE000000000, 64'h4004000000000001};
    logic [15:0] exps [12] = '{
      16'h0001, 16'h0002, 16'hFFFC, 16'h0002, 16'hFFFF, 16'h0001,
      16'h0064, 16'h0000, 16'h0001, 16'h0003, 16'h7FFF, 16'h0003};
    int shs [12] = '{52, 51, 51, 52, 52, 52, 46, 53, 53, 51, 38, 51};
    int exp_lat;
    for (int v = 0; v < 12; v++) begin
      convert(vals[v], 0, 64'd0);
      for (int i = 0; i < 3; i++) begin
        exp_lat = 3 + (shs[v] + steps[i] - 1) / steps[i];
        tests_run++;
        if (sig[i] !== exps[v]) begin
          tests_failed++;
          $display("[TB] FAIL normal[%0d] step%0d value: got %h want %h", v, steps[i], sig[i], exps[v]);
        end
        tests_run++;
        if (lat[i] !== exp_lat || pulses[i] !== 1) begin
          tests_failed++;
          $display("[TB] FAIL normal[%0d] step%0d timing: got lat=%0d pulses=%0d want lat=%0d pulses=1",
                   v, steps[i], lat[i], pulses[i], exp_lat);
        end
        tests_run++;
        if (bsy1[i] !== 1'b1 || bsy[i] !== 1'b0) begin
          tests_failed++;
          $display("[TB] FAIL normal[%0d] step%0d busy: got during=%b after=%b want 1/0",
                   v, steps[i], bsy1[i], bsy[i]);
        end
      end
    end
  endtask

  task automatic test_boundary_negative();
    convert(64'hC0DFFFE000000000, 0, 64'd0);
    for (int i = 0; i < 3; i++) begin
      tests_run++;
      if (sig[i] !== 16'h8000 || lat[i] !== 3 + (38 + steps[i] - 1) / steps[i]) begin
        tests_failed++;
        $display("[TB] FAIL neg32767.5 step%0d: got %h lat=%0d want 8000 lat=%0d",
                 steps[i], sig[i], lat[i], 3 + (38 + steps[i] - 1) / steps[i]);
      end
    end
  endtask

  task automatic test_specials();
    logic [63:0] vals [8] = '{
      64'h40E3880000000000, 64'h7FF8000000000000, 64'hFFF0000000000000,
      64'h3FD0000000000000, 64'h7FF0000000000000, 64'h8000000000000000,
      64'hC0E0000000000000, 64'h0000000000000001};
    logic [15:0] exps [8] = '{
      16'h7FFF, 16'h0000, 16'h8000, 16'h0000, 16'h7FFF, 16'h0000, 16'h8000, 16'h0000};
    for (int v = 0; v < 8; v++) begin
      convert(vals[v], 0, 64'd0);
      for (int i = 0; i < 3; i++) begin
        tests_run++;
        if (sig[i] !== exps[v]) begin
          tests_failed++;
          $display("[TB] FAIL special[%0d] step%0d value: got %h want %h", v, steps[i], sig[i], exps[v]);
        end
        tests_run++;
        if (lat[i] !== 3 || pulses[i] !== 1) begin
          tests_failed++;
          $display("[TB] FAIL special[%0d] step%0d timing: got lat=%0d pulses=%0d want lat=3 pulses=1",
                   v, steps[i], lat[i], pulses[i]);
        end
      end
    end
  endtask

  task automatic test_busy_ignore();
    convert(64'h4004000000000000, 5, 64'hBFF0000000000000);
    for (int i = 0; i < 3; i++) begin
      tests_run++;
      if (sig[i] !== 16'h0002 || pulses[i] !== 1 || lat[i] !== 3 + (51 + steps[i] - 1) / steps[i]) begin
        tests_failed++;
        $display("[TB] FAIL busy_ignore step%0d: got %h pulses=%0d lat=%0d want 0002 pulses=1 lat=%0d",
                 steps[i], sig[i], pulses[i], lat[i], 3 + (51 + steps[i] - 1) / steps[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int mask [3];
    logic [15:0] first [3];
    for (int i = 0; i < 3; i++) mask[i] = 0;
    dbl = 64'h7FF0000000000000;
    enable = 1'b1;
    @(posedge clk_operation); #1;
    dbl = 64'h7FF8000000000000;
    for (int c = 1; c <= 12; c++) begin
      enable = (c <= 5);
      @(posedge clk_operation); #1;
      for (int i = 0; i < 3; i++) begin
        if (rdy[i] === 1'b1) mask[i] = mask[i] | (1 << c);
        if (c == 3) first[i] = sig[i];
      end
    end
    enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tests_run++;
      if (mask[i] !== 32'h108) begin
        tests_failed++;
        $display("[TB] FAIL back_to_back step%0d ready cycles: got mask %h want 108", steps[i], mask[i]);
      end
      tests_run++;
      if (first[i] !== 16'h7FFF || sig[i] !== 16'h0000) begin
        tests_failed++;
        $display("[TB] FAIL back_to_back step%0d values: got %h,%h want 7fff,0000", steps[i], first[i], sig[i]);
      end
    end
    repeat (3) @(posedge clk_operation);
    #1;
  endtask

  task automatic test_reset_mid();
    int late [3];
    convert(64'hBFF0000000000000, 0, 64'd0);
    for (int i = 0; i < 3; i++) begin
      tests_run++;
      if (sig[i] !== 16'hFFFF) begin
        tests_failed++;
        $display("[TB] FAIL pre_reset step%0d: got %h want ffff", steps[i], sig[i]);
      end
    end
    dbl = 64'h3FF0000000000000;
    enable = 1'b1;
    @(posedge clk_operation); #1;
    enable = 1'b0;
    repeat (5) @(posedge clk_operation);
    #1;
    rst = 1'b1;
    @(posedge clk_operation); #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      late[i] = 0;
      tests_run++;
      if (sig[i] !== 16'h0000 || bsy[i] !== 1'b0 || rdy[i] !== 1'b0) begin
        tests_failed++;
        $display("[TB] FAIL reset_mid step%0d: got sig=%h busy=%b ready=%b want 0000/0/0",
                 steps[i], sig[i], bsy[i], rdy[i]);
      end
    end
    for (int c = 0; c < 70; c++) begin
      @(posedge clk_operation); #1;
      for (int i = 0; i < 3; i++) if (rdy[i] === 1'b1) late[i]++;
    end
    for (int i = 0; i < 3; i++) begin
      tests_run++;
      if (late[i] !== 0) begin
        tests_failed++;
        $display("[TB] FAIL reset_mid step%0d stray ready: got %0d pulses want 0", steps[i], late[i]);
      end
    end
    convert(64'hC00C000000000000, 0, 64'd0);
    for (int i = 0; i < 3; i++) begin
      tests_run++;
      if (sig[i] !== 16'hFFFC || pulses[i] !== 1 || lat[i] !== 3 + (51 + steps[i] - 1) / steps[i]) begin
        tests_failed++;
        $display("[TB] FAIL after_reset step%0d: got %h pulses=%0d lat=%0d want fffc pulses=1 lat=%0d",
                 steps[i], sig[i], pulses[i], lat[i], 3 + (51 + steps[i] - 1) / steps[i]);
      end
    end
  endtask

  // Scenario sequence and summary
  initial begin
    test_reset();
    test_normal();
    test_boundary_negative();
    test_specials();
    test_busy_ignore();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
